// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time KMP helpers for the serial pattern detector.
package seq_det_pkg;

    localparam logic MODE_NOOVL = 1'b0;
    localparam logic MODE_OVL   = 1'b1;

    // Longest proper border of the n-bit prefix of pattern.
    // Prefix bit i lives at pattern[len-1-i], because the MSB is received first.
    function automatic int kmp_fail(logic [15:0] pattern, int len, int n);
        int   res;
        logic ok;
        res = 0;
        for (int l = 1; l < n; l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (pattern[len-1-i] != pattern[len-1-(n-l+i)]) ok = 1'b0;
            end
            if (ok) res = l;
        end
        return res;
    endfunction

    // Progress after appending bit b to a j-bit matched prefix.
    // Scans every suffix length and keeps the longest one that is also a pattern prefix.
    // A matching bit gives j+1 through the full-length candidate.
    // A mismatching bit falls back to the longest border.
    function automatic int kmp_next(logic [15:0] pattern, int len, int j, logic b);
        logic [16:0] s;
        int          res;
        logic        ok;
        s = '0;
        for (int i = 0; i < j; i++) s[i] = pattern[len-1-i];
        s[j] = b;
        res  = 0;
        for (int l = 1; l <= j + 1; l++) begin
            if (l <= len) begin
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    if (s[j+1-l+i] != pattern[len-1-i]) ok = 1'b0;
                end
                if (ok) res = l;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter with synchronous active-low clear.
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count events and hold at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                    r_cnt <= '0;
        else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial pattern detector with KMP fallback, valid gating,
// run-time overlap mode and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter int                 CNT_W   = 8,
    localparam int                SW      = $clog2(PAT_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap_en,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic [SW-1:0]    state_dbg
);

    localparam logic [SW-1:0] DET    = SW'(PAT_LEN);
    localparam int            FAIL_N = kmp_fail(16'(PATTERN), PAT_LEN, PAT_LEN);

    logic [SW-1:0]              r_state;
    logic                       r_y;
    logic [SW-1:0]              w_j;
    logic [SW-1:0]              w_step;
    logic [SW-1:0]              w_next;
    logic                       w_inc;
    logic [PAT_LEN-1:0][SW-1:0] w_tab0;
    logic [PAT_LEN-1:0][SW-1:0] w_tab1;

    // The transition table is made of elaboration-time constants, so it needs no storage.
    for (genvar g = 0; g < PAT_LEN; g++) begin : g_tab
        assign w_tab0[g] = SW'(kmp_next(16'(PATTERN), PAT_LEN, g, 1'b0));
        assign w_tab1[g] = SW'(kmp_next(16'(PATTERN), PAT_LEN, g, 1'b1));
    end

    // State register. y is registered next to the state, so x has no combinational path to y.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= '0;
            r_y     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_y     <= (w_next == DET);
        end
    end

    // Next state. Leaving DET restarts from the pattern border (overlap) or from zero.
    always_comb begin
        w_j = r_state;
        if (r_state == DET) w_j = (overlap_en == MODE_OVL) ? SW'(FAIL_N) : '0;
        w_step = '0;
        for (int g = 0; g < PAT_LEN; g++) begin
            if (w_j == SW'(g)) w_step = x ? w_tab1[g] : w_tab0[g];
        end
        w_next = x_valid ? w_step : r_state;
        w_inc  = x_valid && (w_step == DET);
    end

    // Outputs come straight from registers.
    always_comb begin
        y         = r_y;
        state_dbg = r_state;
    end

    seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_inc),
        .o_cnt   (match_cnt)
    );

endmodule
